// File: rtl/la_readout.sv
// Readout sequencer for the logic-analyzer capture RAM.
// Walks addresses 0..count-1 and streams each word over valid/ready.
module la_readout #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [7:0]        COUNT,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [DATA_W-1:0] RAM_DOUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] INDEX
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_in;
  logic               last;

  // one extra count bit so a full-depth run does not wrap to zero
  assign cnt_in = (COUNT > DEPTH_C) ? CNT_W'(DEPTH_C)
                                    : CNT_W'(COUNT);
  assign last = (CNT_W'(addr_q) + CNT_W'(1)) == cnt_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          cnt_d   = cnt_in;
          valid_d = 1'b0;
          if (cnt_in != '0) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        data_d  = RAM_DOUT;
        idx_d   = addr_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (READY) begin
          valid_d = 1'b0;
          if (last) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ABORT && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RAM_ADDR = addr_q;
  assign DATA_OUT = data_q;
  assign INDEX    = idx_q;
  assign VALID    = valid_q;
  assign BUSY     = state_q != IDLE;
  assign DONE     = state_q == FIN;

endmodule

// File: tb/tb_la_readout.sv
// Directed bench for la_readout.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_la_readout;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        ABORT;
  logic [7:0]  COUNT;
  logic [4:0]  RAM_ADDR;
  logic [31:0] RAM_DOUT;
  logic [31:0] DATA_OUT;
  logic        VALID;
  logic        READY;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  INDEX;

  logic [31:0] mem [32];

  int checks;
  int failures;

  logic [31:0] w_data [64];
  logic [4:0]  w_idx  [64];
  int          n_w;
  int          done_cyc;
  int          n_done;
  int          unstable;
  bit          vseen;

  la_readout #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .COUNT(COUNT), .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY),
    .BUSY(BUSY), .DONE(DONE), .INDEX(INDEX)
  );

  assign RAM_DOUT = mem[RAM_ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue START for one edge; returns in cycle 1 after the START edge.
  task automatic kick(input logic [7:0] cnt);
    COUNT = cnt;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Collects handshaken words until DONE, idle, or cycle budget.
  task automatic drain(input int max_c, input int stall_idx,
                       input int stall_len, input int inj_idx);
    logic [31:0] pd;
    logic [4:0]  pi;
    bit          pend;
    bit          injected;
    int          sc;
    n_w = 0; done_cyc = -1; n_done = 0;
    unstable = 0; vseen = 0;
    pend = 0; injected = 0; sc = 0;
    pd = '0; pi = '0;
    for (int c = 1; c <= max_c; c++) begin
      if (pend && (!VALID || DATA_OUT !== pd || INDEX !== pi))
        unstable++;
      if (VALID) vseen = 1;
      START = 1'b0;
      if (VALID && int'(INDEX) == inj_idx && !injected) begin
        START = 1'b1;
        COUNT = 8'd2;
        injected = 1;
      end
      READY = 1'b1;
      if (VALID && int'(INDEX) == stall_idx && sc < stall_len) begin
        READY = 1'b0;
        sc++;
      end
      if (VALID && READY) begin
        if (n_w < 64) begin
          w_data[n_w] = DATA_OUT;
          w_idx[n_w]  = INDEX;
        end
        n_w++;
        pend = 0;
      end else begin
        pend = VALID;
      end
      pd = DATA_OUT;
      pi = INDEX;
      if (DONE) begin
        n_done++;
        done_cyc = c;
        break;
      end
      if (!BUSY) break;
      step();
    end
    START = 1'b0;
    READY = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    checks++;
    if (RAM_ADDR !== 5'd0 || DATA_OUT !== 32'd0 || VALID !== 1'b0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || INDEX !== 5'd0) begin
      failures++;
      $display("FAIL reset: addr=%0d data=%h v=%b b=%b d=%b idx=%0d want all 0",
               RAM_ADDR, DATA_OUT, VALID, BUSY, DONE, INDEX);
    end
  endtask

  task automatic test_basic();
    READY = 1'b1;
    kick(8'd4);
    checks++;
    if (BUSY !== 1'b1 || VALID !== 1'b0 || RAM_ADDR !== 5'd0) begin
      failures++;
      $display("FAIL basic_c1: busy=%b valid=%b addr=%0d want 1 0 0",
               BUSY, VALID, RAM_ADDR);
    end
    drain(40, -1, 0, -1);
    checks++;
    if (n_w !== 4) begin
      failures++;
      $display("FAIL basic_words: got %0d want 4", n_w);
    end
    for (int i = 0; i < 4 && i < n_w; i++) begin
      checks++;
      if (w_data[i] !== 32'hA500_0000 + i || w_idx[i] !== 5'(i)) begin
        failures++;
        $display("FAIL basic_word%0d: data=%h idx=%0d want %h %0d",
                 i, w_data[i], w_idx[i], 32'hA500_0000 + i, i);
      end
    end
    checks++;
    if (done_cyc !== 9 || n_done !== 1) begin
      failures++;
      $display("FAIL basic_done: cycle=%0d n=%0d want 9 1", done_cyc, n_done);
    end
    step();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || VALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: busy=%b done=%b valid=%b want 0 0 0",
               BUSY, DONE, VALID);
    end
  endtask

  task automatic test_backpressure();
    kick(8'd3);
    drain(40, 1, 5, -1);
    checks++;
    if (n_w !== 3 || unstable !== 0) begin
      failures++;
      $display("FAIL bp_stream: words=%0d unstable=%0d want 3 0", n_w, unstable);
    end
    for (int i = 0; i < 3 && i < n_w; i++) begin
      checks++;
      if (w_data[i] !== 32'hA500_0000 + i || w_idx[i] !== 5'(i)) begin
        failures++;
        $display("FAIL bp_word%0d: data=%h idx=%0d want %h %0d",
                 i, w_data[i], w_idx[i], 32'hA500_0000 + i, i);
      end
    end
    checks++;
    if (done_cyc !== 12 || n_done !== 1) begin
      failures++;
      $display("FAIL bp_done: cycle=%0d n=%0d want 12 1", done_cyc, n_done);
    end
    step();
  endtask

  task automatic test_zero_clamp();
    bit ok;
    kick(8'd0);
    drain(10, -1, 0, -1);
    checks++;
    if (done_cyc !== 1 || n_done !== 1 || vseen !== 0 || n_w !== 0) begin
      failures++;
      $display("FAIL zero: done_cyc=%0d n=%0d vseen=%0d words=%0d want 1 1 0 0",
               done_cyc, n_done, vseen, n_w);
    end
    step();
    kick(8'h28);
    drain(120, -1, 0, -1);
    checks++;
    if (n_w !== 32 || done_cyc !== 65 || n_done !== 1) begin
      failures++;
      $display("FAIL clamp: words=%0d done_cyc=%0d n=%0d want 32 65 1",
               n_w, done_cyc, n_done);
    end
    ok = 1;
    for (int i = 0; i < 32 && i < n_w; i++)
      if (w_data[i] !== 32'hA500_0000 + i || w_idx[i] !== 5'(i)) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clamp_words: sequence wrong, last idx=%0d want 31",
               n_w > 0 ? int'(w_idx[(n_w > 64 ? 64 : n_w) - 1]) : -1);
    end
    step();
  endtask

  task automatic test_start_busy();
    kick(8'd6);
    drain(40, -1, 0, 2);
    checks++;
    if (n_w !== 6 || done_cyc !== 13 || n_done !== 1) begin
      failures++;
      $display("FAIL start_busy: words=%0d done_cyc=%0d n=%0d want 6 13 1",
               n_w, done_cyc, n_done);
    end
    checks++;
    if (n_w >= 6 && (w_data[5] !== 32'hA500_0005 || w_idx[5] !== 5'd5)) begin
      failures++;
      $display("FAIL start_busy_last: data=%h idx=%0d want a5000005 5",
               w_data[5], w_idx[5]);
    end
    step();
  endtask

  task automatic test_abort();
    bit saw_done;
    READY = 1'b1;
    kick(8'd5);
    step();
    step();
    step();
    checks++;
    if (VALID !== 1'b1 || INDEX !== 5'd1) begin
      failures++;
      $display("FAIL abort_pre: valid=%b idx=%0d want 1 1", VALID, INDEX);
    end
    READY = 1'b0;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    READY = 1'b1;
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 ||
        DATA_OUT !== 32'hA500_0001) begin
      failures++;
      $display("FAIL abort: valid=%b busy=%b done=%b data=%h want 0 0 0 a5000001",
               VALID, BUSY, DONE, DATA_OUT);
    end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (DONE) saw_done = 1;
      step();
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_nodone: done=1 want 0");
    end
    kick(8'd2);
    checks++;
    if (RAM_ADDR !== 5'd0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart: addr=%0d busy=%b want 0 1", RAM_ADDR, BUSY);
    end
    drain(20, -1, 0, -1);
    checks++;
    if (n_w !== 2 || done_cyc !== 5 || w_data[0] !== 32'hA500_0000 ||
        w_idx[1] !== 5'd1) begin
      failures++;
      $display("FAIL abort_rerun: words=%0d done_cyc=%0d d0=%h i1=%0d want 2 5 a5000000 1",
               n_w, done_cyc, w_data[0], w_idx[1]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    READY = 1'b1;
    kick(8'd5);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (RAM_ADDR !== 5'd3 || VALID !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: addr=%0d valid=%b busy=%b want 3 0 1",
               RAM_ADDR, VALID, BUSY);
    end
    RESET = 1'b1;
    START = 1'b1;
    COUNT = 8'd4;
    step();
    RESET = 1'b0;
    START = 1'b0;
    checks++;
    if (RAM_ADDR !== 5'd0 || DATA_OUT !== 32'd0 || VALID !== 1'b0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || INDEX !== 5'd0) begin
      failures++;
      $display("FAIL rst_mid: addr=%0d data=%h v=%b b=%b d=%b idx=%0d want all 0",
               RAM_ADDR, DATA_OUT, VALID, BUSY, DONE, INDEX);
    end
    step();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL rst_start_ignored: busy=%b done=%b want 0 0", BUSY, DONE);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i;
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    COUNT = 8'd0;
    READY = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_clamp();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
